// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg
//   Shared definitions for the data-memory sequencer and its opcode decoder:
//   default datapath widths, access-kind encodings and sequencer states.
//   Optional build macro used by the sequencer: RMW_DUMMY_WRITE_EN.
package mem_access_sequencer_pkg;

  localparam int unsigned DEF_REG_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_IMM,
    ACC_LOAD,
    ACC_STORE,
    ACC_RMW
  } acc_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_DUMMY_WR,
    ST_WRITE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Bundles the fetcher handshake, register/ALU operand path and the
//   synchronous data-memory bus around the sequencer.
//   master : sequencer side (drives memory strobes, operand, done, status)
//   slave  : environment side (fetcher, register file, ALU, memory)
interface mem_access_sequencer_if
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  instruction_ready;
  logic [REG_WIDTH-1:0]  instruction_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [REG_WIDTH-1:0]  imm_in;
  logic [REG_WIDTH-1:0]  store_data;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic [REG_WIDTH-1:0]  alu_result;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [REG_WIDTH-1:0]  operand_out;
  logic                  operand_valid;
  logic                  instruction_done;
  logic                  busy;
  logic                  overrun_err;

  modport master (
    input  instruction_ready, instruction_in, addr_in, imm_in, store_data,
           mem_rdata, alu_result,
    output mem_addr, mem_wdata, mem_we, mem_re, operand_out, operand_valid,
           instruction_done, busy, overrun_err
  );

  modport slave (
    output instruction_ready, instruction_in, addr_in, imm_in, store_data,
           mem_rdata, alu_result,
    input  mem_addr, mem_wdata, mem_we, mem_re, operand_out, operand_valid,
           instruction_done, busy, overrun_err
  );

endinterface

// File: rtl/mem_access_sequencer_access_decode.sv
// access_decode
//   Combinational 6502 opcode -> data-memory access kind classifier.
//   Ports:
//     opcode : 8-bit opcode (aaa = [7:5], bbb = [4:2], cc = [1:0])
//     kind   : ACC_NONE / ACC_IMM / ACC_LOAD / ACC_STORE / ACC_RMW
//   Classes are tested in priority order IMM, STORE, RMW, LOAD, NONE.
module access_decode
  import mem_access_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output acc_kind_e  kind
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;
  logic       bbb_odd;
  logic       is_imm;
  logic       is_store;
  logic       is_rmw;
  logic       is_load;

  assign aaa     = opcode[7:5];
  assign bbb     = opcode[4:2];
  assign cc      = opcode[1:0];
  // {001,011,101,111}: zero page, absolute and their indexed forms
  assign bbb_odd = bbb[0];

  always_comb begin
    is_imm   = ((cc == 2'b01) && (bbb == 3'b010)) ||
               (opcode == 8'hA0) || (opcode == 8'hA2) ||
               (opcode == 8'hC0) || (opcode == 8'hE0);

    is_store = (aaa == 3'b100) &&
               (((cc == 2'b01) && (bbb != 3'b010)) ||
                ((cc != 2'b01) && ((bbb == 3'b001) || (bbb == 3'b011) ||
                                   (bbb == 3'b101))));

    is_rmw   = (cc == 2'b10) && (aaa != 3'b100) && (aaa != 3'b101) && bbb_odd;

    is_load  = ((cc == 2'b01) && (aaa != 3'b100)) ||
               ((cc == 2'b10) && (aaa == 3'b101) && bbb_odd) ||
               ((cc == 2'b00) &&
                ((aaa == 3'b001) || (aaa == 3'b101) ||
                 (aaa == 3'b110) || (aaa == 3'b111)) &&
                ((bbb == 3'b001) || (bbb == 3'b011))) ||
               ((cc == 2'b00) && (aaa == 3'b101) &&
                ((bbb == 3'b101) || (bbb == 3'b111)));

    kind = ACC_NONE;
    if (is_imm)        kind = ACC_IMM;
    else if (is_store) kind = ACC_STORE;
    else if (is_rmw)   kind = ACC_RMW;
    else if (is_load)  kind = ACC_LOAD;
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Data-memory phase of a 6502 instruction. Accepts a decoded instruction on
//   the rising edge of instruction_ready, runs the load/store/read-modify-write
//   sequence against a 1-cycle-latency synchronous memory, presents the operand
//   to the ALU/register file and pulses instruction_done back to the fetcher.
//   Ports:
//     phi1    : clock, all state updates on the rising edge
//     reset_n : asynchronous active-low reset; cancels any transaction
//     bus     : mem_access_sequencer_if.master (handshake, operand, memory bus)
//   Build macro:
//     RMW_DUMMY_WRITE_EN : RMW rewrites the original value (DUMMY_WR) before
//                          the modified value, as the original 6502 does.
//   Strobes and data outputs decode straight from registered state so a reset
//   removes them asynchronously with no partial write.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   phi1,
  input  logic                   reset_n,
  mem_access_sequencer_if.master bus
);

  seq_state_e            state_q, state_d;
  acc_kind_e             kind_q, kind_d;
  acc_kind_e             dec_kind;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  imm_q, imm_d;
  logic                  ready_dly_q, ready_dly_d;
  logic                  overrun_q, overrun_d;
  logic                  ready_rise;
`ifdef RMW_DUMMY_WRITE_EN
  logic [REG_WIDTH-1:0]  data_q, data_d;
`endif

  access_decode u_access_decode (
    .opcode (bus.instruction_in[7:0]),
    .kind   (dec_kind)
  );

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= ACC_NONE;
      addr_q      <= '0;
      imm_q       <= '0;
      ready_dly_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RMW_DUMMY_WRITE_EN
      data_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      imm_q       <= imm_d;
      ready_dly_q <= ready_dly_d;
      overrun_q   <= overrun_d;
`ifdef RMW_DUMMY_WRITE_EN
      data_q      <= data_d;
`endif
    end
  end

  always_comb begin
    ready_rise  = bus.instruction_ready & ~ready_dly_q;

    state_d     = state_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    imm_d       = imm_q;
    ready_dly_d = bus.instruction_ready;
    overrun_d   = overrun_q;
`ifdef RMW_DUMMY_WRITE_EN
    data_d      = data_q;
`endif

    bus.mem_addr         = '0;
    bus.mem_wdata        = '0;
    bus.mem_we           = 1'b0;
    bus.mem_re           = 1'b0;
    bus.operand_out      = '0;
    bus.operand_valid    = 1'b0;
    bus.instruction_done = 1'b0;
    bus.busy             = (state_q != ST_IDLE);
    bus.overrun_err      = overrun_q;

    // A new instruction arriving anywhere but IDLE (DONE included) is dropped.
    if (ready_rise && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ready_rise) begin
          kind_d = dec_kind;
          addr_d = bus.addr_in;
          imm_d  = bus.imm_in;
          case (dec_kind)
            ACC_LOAD, ACC_RMW: state_d = ST_READ;
            ACC_STORE:         state_d = ST_WRITE;
            default:           state_d = ST_DONE;
          endcase
        end
      end

      ST_READ: begin
        bus.mem_addr = addr_q;
        bus.mem_re   = 1'b1;
        state_d      = ST_WAIT_RD;
      end

      ST_WAIT_RD: begin
        bus.mem_addr      = addr_q;
        bus.operand_out   = bus.mem_rdata;
        bus.operand_valid = 1'b1;
        if (kind_q == ACC_RMW) begin
`ifdef RMW_DUMMY_WRITE_EN
          data_d  = bus.mem_rdata;
          state_d = ST_DUMMY_WR;
`else
          state_d = ST_WRITE;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DUMMY_WR: begin
        bus.mem_addr = addr_q;
        bus.mem_we   = 1'b1;
`ifdef RMW_DUMMY_WRITE_EN
        // Rewrite the fetched value while capturing the ALU result.
        bus.mem_wdata = data_q;
        data_d        = bus.alu_result;
`endif
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        bus.mem_addr = addr_q;
        bus.mem_we   = 1'b1;
        if (kind_q == ACC_RMW) begin
`ifdef RMW_DUMMY_WRITE_EN
          bus.mem_wdata = data_q;
`else
          bus.mem_wdata = bus.alu_result;
`endif
        end else begin
          bus.mem_wdata = bus.store_data;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        bus.mem_addr         = addr_q;
        bus.instruction_done = 1'b1;
        if (kind_q == ACC_IMM) begin
          bus.operand_out   = imm_q;
          bus.operand_valid = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
`timescale 1ns/1ps
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  localparam int unsigned RW = 8;
  localparam int unsigned AW = 16;

  localparam int EV_RD   = 1;
  localparam int EV_WR   = 2;
  localparam int EV_OP   = 3;
  localparam int EV_DONE = 4;

  typedef struct {
    int          kind;
    int          rel;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [7:0] opc;
    acc_kind_e  kind;
  } vec_t;

  logic phi1 = 1'b0;
  logic reset_n;

  mem_access_sequencer_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

  mem_access_sequencer #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .phi1    (phi1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 phi1 = ~phi1;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t0       = 0;
  ev_t  sb[$];
  logic [7:0] mem_model [0:65535];
  logic [7:0] alu_val;

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic push(int kind, int rel, logic [15:0] addr, logic [7:0] data);
    ev_t e;
    e.kind = kind; e.rel = rel; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Reference timing of each access class, cycle 1 = first cycle after accept.
  task automatic push_expected(acc_kind_e k, logic [15:0] addr, logic [7:0] imm,
                               logic [7:0] st, logic [7:0] rd, logic [7:0] alu);
    case (k)
      ACC_IMM: begin
        push(EV_OP, 1, 16'h0, imm);
        push(EV_DONE, 1, 16'h0, 8'h0);
      end
      ACC_LOAD: begin
        push(EV_RD, 1, addr, 8'h0);
        push(EV_OP, 2, 16'h0, rd);
        push(EV_DONE, 3, 16'h0, 8'h0);
      end
      ACC_STORE: begin
        push(EV_WR, 1, addr, st);
        push(EV_DONE, 2, 16'h0, 8'h0);
      end
      ACC_RMW: begin
        push(EV_RD, 1, addr, 8'h0);
        push(EV_OP, 2, 16'h0, rd);
`ifdef RMW_DUMMY_WRITE_EN
        push(EV_WR, 3, addr, rd);
        push(EV_WR, 4, addr, alu);
        push(EV_DONE, 5, 16'h0, 8'h0);
`else
        push(EV_WR, 3, addr, alu);
        push(EV_DONE, 4, 16'h0, 8'h0);
`endif
      end
      default: push(EV_DONE, 1, 16'h0, 8'h0);
    endcase
  endtask

  task automatic observe(int kind, int rel, logic [15:0] a, logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      check_eq("unexpected_event", 32'(kind), 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq("ev_kind", 32'(kind), 32'(e.kind));
    check_eq("ev_cycle", 32'(rel), 32'(e.rel));
    if (e.kind == EV_RD || e.kind == EV_WR) check_eq("ev_addr", 32'(a), 32'(e.addr));
    if (e.kind == EV_WR || e.kind == EV_OP) check_eq("ev_data", 32'(d), 32'(e.data));
  endtask

  // Synchronous memory and ALU models.
  always @(posedge phi1) begin
    cyc = cyc + 1;
    bus.mem_rdata  <= bus.mem_re ? mem_model[bus.mem_addr] : 8'hEE;
    bus.alu_result <= bus.operand_valid ? alu_val : 8'hEE;
  end

  // Output monitor: every strobe/pulse becomes an observed event.
  always @(negedge phi1) begin
    if (reset_n) begin
      if (bus.mem_re || bus.mem_we)
        check_eq("strobe_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
      if (bus.mem_re)           observe(EV_RD, cyc - t0, bus.mem_addr, 8'h0);
      if (bus.mem_we)           observe(EV_WR, cyc - t0, bus.mem_addr, bus.mem_wdata);
      if (bus.operand_valid)    observe(EV_OP, cyc - t0, 16'h0, bus.operand_out);
      if (bus.instruction_done) observe(EV_DONE, cyc - t0, 16'h0, 8'h0);
    end
  end

  task automatic drive(logic [7:0] opc, logic [15:0] addr, logic [7:0] imm, logic [7:0] st);
    bus.instruction_in    = opc;
    bus.addr_in           = addr;
    bus.imm_in            = imm;
    bus.store_data        = st;
    bus.instruction_ready = 1'b1;
    t0 = cyc;
  endtask

  task automatic end_txn(string tag);
    bus.instruction_ready = 1'b0;
    @(negedge phi1);
    check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_idle_addr"}, 32'(bus.mem_addr), 32'd0);
    sb.delete();
  endtask

  // Called at a negedge; ready held high for 'hold' cycles.
  task automatic run_txn(string tag, acc_kind_e k, logic [7:0] opc, logic [15:0] addr,
                         logic [7:0] imm, logic [7:0] st, int hold);
    push_expected(k, addr, imm, st, mem_model[addr], alu_val);
    drive(opc, addr, imm, st);
    repeat (hold) @(negedge phi1);
    end_txn(tag);
  endtask

  vec_t vecs[$];
  int   rst_wait;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.instruction_ready = 1'b0;
    bus.instruction_in = '0;
    bus.addr_in = '0;
    bus.imm_in = '0;
    bus.store_data = '0;
    alu_val = 8'h00;
    mem_model[16'h1234] = 8'h5A;
    mem_model[16'h0020] = 8'h41;
    for (int i = 0; i < 16; i++) mem_model[16'h0100 + 16'(i)] = 8'h30 + 8'(i);

    repeat (3) @(negedge phi1);
    check_eq("rst_flags", {26'd0, bus.mem_we, bus.mem_re, bus.operand_valid,
                           bus.instruction_done, bus.busy, bus.overrun_err}, 32'd0);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rst_operand", 32'(bus.operand_out), 32'd0);
    reset_n = 1'b1;
    @(negedge phi1);

    run_txn("lda_abs", ACC_LOAD, 8'hAD, 16'h1234, 8'h00, 8'h00, 5);
    run_txn("sta_zpg", ACC_STORE, 8'h85, 16'h0010, 8'h00, 8'h77, 5);
    alu_val = 8'h42;
    run_txn("inc_zpg", ACC_RMW, 8'hE6, 16'h0020, 8'h00, 8'h00, 8);
    run_txn("ldx_imm", ACC_IMM, 8'hA2, 16'h0300, 8'h99, 8'h00, 4);
    run_txn("tax", ACC_NONE, 8'hAA, 16'h0301, 8'h00, 8'h00, 4);

    // Level held high for 10+ cycles: one transaction only.
    run_txn("lda_held", ACC_LOAD, 8'hAD, 16'h1234, 8'h00, 8'h00, 12);
    check_eq("no_overrun_yet", {31'd0, bus.overrun_err}, 32'd0);

    // Second rising edge lands while in WAIT_RD.
    push_expected(ACC_LOAD, 16'h1234, 8'h00, 8'h00, 8'h5A, alu_val);
    drive(8'hAD, 16'h1234, 8'h00, 8'h00);
    @(negedge phi1);
    bus.instruction_ready = 1'b0;
    @(negedge phi1);
    bus.instruction_ready = 1'b1;
    @(negedge phi1);
    check_eq("overrun_set", {31'd0, bus.overrun_err}, 32'd1);
    repeat (4) @(negedge phi1);
    end_txn("overrun");
    check_eq("overrun_sticky", {31'd0, bus.overrun_err}, 32'd1);

    // Decode table across access classes.
    vecs = '{'{8'hA9, ACC_IMM},   '{8'h8D, ACC_STORE}, '{8'h0E, ACC_RMW},
             '{8'hBE, ACC_LOAD},  '{8'h4C, ACC_NONE},  '{8'h2C, ACC_LOAD},
             '{8'h96, ACC_STORE}, '{8'h91, ACC_STORE}, '{8'hE0, ACC_IMM},
             '{8'h48, ACC_NONE},  '{8'hDE, ACC_RMW},   '{8'hBC, ACC_LOAD},
             '{8'h8C, ACC_STORE}, '{8'h0A, ACC_NONE}};
    for (int i = 0; i < vecs.size(); i++) begin
      alu_val = 8'h90 + 8'(i);
      run_txn("decode", vecs[i].kind, vecs[i].opc, 16'h0100 + 16'(i),
              8'hC0 + 8'(i), 8'h60 + 8'(i), 8);
    end

    // Reset asserted while the RMW final write is on the bus.
    alu_val = 8'h42;
    push(EV_RD, 1, 16'h0020, 8'h0);
    push(EV_OP, 2, 16'h0, 8'h41);
`ifdef RMW_DUMMY_WRITE_EN
    push(EV_WR, 3, 16'h0020, 8'h41);
    rst_wait = 4;
`else
    rst_wait = 3;
`endif
    drive(8'hE6, 16'h0020, 8'h00, 8'h00);
    repeat (rst_wait) @(posedge phi1);
    #1;
    check_eq("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
    reset_n = 1'b0;
    bus.instruction_ready = 1'b0;
    #1;
    check_eq("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
    check_eq("mid_rst_flags", {26'd0, bus.mem_we, bus.mem_re, bus.operand_valid,
                               bus.instruction_done, bus.busy, bus.overrun_err}, 32'd0);
    check_eq("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("mid_rst_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge phi1);
    reset_n = 1'b1;
    repeat (3) @(negedge phi1);
    run_txn("lda_after_rst", ACC_LOAD, 8'hAD, 16'h1234, 8'h00, 8'h00, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
